// File: rtl/baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : baud_gen
// Brief    : UART baud-rate generator: Rx oversample strobe and Tx bit strobe
//            with a runtime-programmable divisor and Rx phase resync.
// Revision : 1.0 - initial release
// ============================================================================
module baud_gen #(
  parameter int CLK_HZ      = 50000000,
  parameter int BAUD        = 115200,
  parameter int OVERSAMPLE  = 16,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = CLK_HZ / (BAUD * OVERSAMPLE)
) (
  input  logic                 clk_50m,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 div_wr,
  input  logic [DIV_WIDTH-1:0] div_in,
  input  logic                 rx_resync,
  output logic                 rx_tick,
  output logic                 tx_tick,
  output logic [DIV_WIDTH-1:0] div_cur,
  output logic                 div_err
);

  localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  localparam logic [DIV_WIDTH-1:0] c_ONE     = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] c_TWO     = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] c_DEF_DIV = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [OS_W-1:0]      c_OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]      c_OS_ONE  = OS_W'(1);

  generate
    if (OVERSAMPLE < 2) begin : g_bad_oversample
      $error("baud_gen: OVERSAMPLE must be at least 2");
    end
    if ((DEFAULT_DIV < 2) || ((DEFAULT_DIV >> DIV_WIDTH) != 0)) begin : g_bad_default_div
      $error("baud_gen: DEFAULT_DIV must satisfy 2 <= DEFAULT_DIV < 2**DIV_WIDTH");
    end
  endgenerate

  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH-1:0] r_rx_pre;
  logic [DIV_WIDTH-1:0] r_tx_pre;
  logic [OS_W-1:0]      r_tx_os;
  logic                 r_rx_tick;
  logic                 r_tx_tick;
  logic                 r_div_err;

  logic                 w_wr_ok;
  logic [DIV_WIDTH-1:0] w_div_last;
  logic                 w_rx_wrap;
  logic                 w_tx_wrap;

  assign w_wr_ok    = div_wr && (div_in >= c_TWO);
  assign w_div_last = r_div - c_ONE;
  assign w_rx_wrap  = (r_rx_pre == w_div_last);
  assign w_tx_wrap  = (r_tx_pre == w_div_last);

  always_ff @(posedge clk_50m) begin
    if (reset) begin
      r_div     <= c_DEF_DIV;
      r_rx_pre  <= '0;
      r_tx_pre  <= '0;
      r_tx_os   <= '0;
      r_rx_tick <= 1'b0;
      r_tx_tick <= 1'b0;
      r_div_err <= 1'b0;
    end else begin
      // A rejected write only raises the error flag; counting carries on.
      r_div_err <= div_wr && !w_wr_ok;

      if (w_wr_ok) begin
        r_div     <= div_in;
        r_rx_pre  <= '0;
        r_tx_pre  <= '0;
        r_tx_os   <= '0;
        r_rx_tick <= 1'b0;
        r_tx_tick <= 1'b0;
      end else begin
        if (rx_resync) begin
          r_rx_pre  <= '0;
          r_rx_tick <= 1'b0;
        end else if (en) begin
          if (w_rx_wrap) begin
            r_rx_pre  <= '0;
            r_rx_tick <= 1'b1;
          end else begin
            r_rx_pre  <= r_rx_pre + c_ONE;
            r_rx_tick <= 1'b0;
          end
        end else begin
          r_rx_tick <= 1'b0;
        end

        // Tx path keeps its own prescaler so an Rx resync never shifts it.
        if (en) begin
          if (w_tx_wrap) begin
            r_tx_pre  <= '0;
            r_tx_os   <= (r_tx_os == c_OS_LAST) ? '0 : (r_tx_os + c_OS_ONE);
            r_tx_tick <= (r_tx_os == c_OS_LAST);
          end else begin
            r_tx_pre  <= r_tx_pre + c_ONE;
            r_tx_tick <= 1'b0;
          end
        end else begin
          r_tx_tick <= 1'b0;
        end
      end
    end
  end

  assign rx_tick = r_rx_tick;
  assign tx_tick = r_tx_tick;
  assign div_cur = r_div;
  assign div_err = r_div_err;

endmodule
`default_nettype wire

// File: tb/tb_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_baud_gen
// Brief    : Directed, self-checking bench for baud_gen (vector table plus
//            multi-cycle cadence sequences).
// Revision : 1.0 - initial release
// ============================================================================
module tb_baud_gen;

  logic        clk;
  logic        rst;
  logic        en;
  logic        div_wr;
  logic [15:0] div_in;
  logic        rx_resync;
  logic        rx_tick;
  logic        tx_tick;
  logic [15:0] div_cur;
  logic        div_err;

  int n_tests = 0;
  int n_fail  = 0;

  baud_gen dut (
    .clk_50m  (clk),
    .reset    (rst),
    .en       (en),
    .div_wr   (div_wr),
    .div_in   (div_in),
    .rx_resync(rx_resync),
    .rx_tick  (rx_tick),
    .tx_tick  (tx_tick),
    .div_cur  (div_cur),
    .div_err  (div_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached (got running, want finished)");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        rst;
    logic        en;
    logic        wr;
    logic [15:0] din;
    logic        rs;
    logic        exp_rx;
    logic        exp_tx;
    logic [15:0] exp_div;
    logic        exp_err;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic w,
                       input logic [15:0] d, input logic s);
    rst = r; en = e; div_wr = w; div_in = d; rx_resync = s;
  endtask

  task automatic do_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string nm, input logic erx, input logic etx,
                            input int ediv, input logic eerr);
    check({nm, "_rx"},  int'(rx_tick), int'(erx));
    check({nm, "_tx"},  int'(tx_tick), int'(etx));
    check({nm, "_div"}, int'(div_cur), ediv);
    check({nm, "_err"}, int'(div_err), int'(eerr));
  endtask

  // Runs n enabled edges; edge k (1-based) expects a tick when k >= first
  // and (k - first) is a multiple of the period.
  task automatic run_cadence(input string nm, input int n, input int rx_per,
                             input int rx_first, input int tx_per,
                             input int tx_first, input int ediv);
    int bad = 0;
    int first_bad = 0;
    logic erx, etx;
    drive(1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
    for (int k = 1; k <= n; k++) begin
      do_edge();
      erx = (k >= rx_first) && (((k - rx_first) % rx_per) == 0);
      etx = (k >= tx_first) && (((k - tx_first) % tx_per) == 0);
      if (rx_tick !== erx || tx_tick !== etx || div_cur !== 16'(ediv) || div_err !== 1'b0) begin
        if (bad == 0) first_bad = k;
        bad++;
      end
    end
    check({nm, "_mismatched_edges"}, bad, 0);
    if (bad != 0) $display("  %s first bad edge %0d", nm, first_bad);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
    do_edge();
  endtask

  initial begin
    // {rst, en, wr, din, rs, exp_rx, exp_tx, exp_div, exp_err}
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd27, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 16'd2, 1'b0, 1'b0, 1'b0, 16'd2,  1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd2,  1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 16'd2,  1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd2,  1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 16'd2,  1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 16'd2,  1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 16'd2,  1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 16'd1, 1'b0, 1'b0, 1'b0, 16'd2,  1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd2,  1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd2,  1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 16'd2,  1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd2,  1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd2,  1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd2,  1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 16'd2,  1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd2,  1'b0};
    vecs[17] = '{1'b0, 1'b1, 1'b1, 16'd3, 1'b1, 1'b0, 1'b0, 16'd3,  1'b0};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd3,  1'b0};
    vecs[19] = '{1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd3,  1'b0};
    vecs[20] = '{1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 16'd3,  1'b0};
    vecs[21] = '{1'b1, 1'b1, 1'b1, 16'd7, 1'b0, 1'b0, 1'b0, 16'd27, 1'b0};

    drive(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);

    // Short-divisor vector table: write/err/resync/enable priorities.
    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].wr, vecs[i].din, vecs[i].rs);
      do_edge();
      check_outs($sformatf("vec%0d", i), vecs[i].exp_rx, vecs[i].exp_tx,
                 int'(vecs[i].exp_div), vecs[i].exp_err);
    end

    // Default cadence from reset: rx every 27, tx every 432.
    do_reset();
    check_outs("s1_reset", 1'b0, 1'b0, 27, 1'b0);
    run_cadence("s1", 1000, 27, 27, 432, 432, 27);

    // Mid-count write of 5, with rejected writes of 0 and 1 during the run.
    do_reset();
    run_cadence("s2_pre", 100, 27, 27, 432, 432, 27);
    drive(1'b0, 1'b1, 1'b1, 16'd5, 1'b0);
    do_edge();
    check_outs("s2_wr", 1'b0, 1'b0, 5, 1'b0);
    begin
      int bad = 0;
      for (int j = 1; j <= 200; j++) begin
        logic erx, etx, eerr;
        drive(1'b0, 1'b1, (j == 37) || (j == 63), (j == 63) ? 16'd1 : 16'd0, 1'b0);
        do_edge();
        erx  = (j % 5) == 0;
        etx  = (j % 80) == 0;
        eerr = (j == 37) || (j == 63);
        if (rx_tick !== erx || tx_tick !== etx || div_cur !== 16'd5 || div_err !== eerr) bad++;
        if (j == 37) check("s2_err_din0", int'(div_err), 1);
        if (j == 38) check("s2_err_clear", int'(div_err), 0);
        if (j == 63) check("s2_err_din1", int'(div_err), 1);
      end
      check("s2_mismatched_edges", bad, 0);
    end

    // Resync at rx_pre=13: next rx 27 edges later, tx stays on the 432 grid.
    do_reset();
    run_cadence("s4_pre", 13, 27, 27, 432, 432, 27);
    drive(1'b0, 1'b1, 1'b0, 16'd0, 1'b1);
    do_edge();
    check_outs("s4_resync", 1'b0, 1'b0, 27, 1'b0);
    run_cadence("s4_post", 886, 27, 27, 432, 418, 27);

    // Enable low for 100 cycles at rx_pre=10.
    do_reset();
    run_cadence("s5_pre", 10, 27, 27, 432, 432, 27);
    begin
      int ticks = 0;
      drive(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
      for (int j = 0; j < 100; j++) begin
        do_edge();
        if (rx_tick !== 1'b0 || tx_tick !== 1'b0) ticks++;
      end
      check("s5_ticks_while_disabled", ticks, 0);
    end
    run_cadence("s5_post", 500, 27, 17, 432, 422, 27);

    // Reset while tx_os=15 with div=5 restores the default cadence.
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 16'd5, 1'b0);
    do_edge();
    check_outs("s6_wr", 1'b0, 1'b0, 5, 1'b0);
    run_cadence("s6_pre", 76, 5, 5, 80, 80, 5);
    drive(1'b1, 1'b1, 1'b0, 16'd0, 1'b0);
    do_edge();
    check_outs("s6_reset", 1'b0, 1'b0, 27, 1'b0);
    run_cadence("s6_post", 432, 27, 27, 432, 432, 27);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/baud_gen.md
# baud_gen

Parametrised baud-rate generator for the UART Tx/Rx pair, successor to the fixed 115200-baud 50 MHz divider. It produces a single-cycle Rx oversample strobe (OVERSAMPLE × baud) and a single-cycle Tx bit strobe (1 × baud) from the board clock. It adds a runtime-programmable divisor, a gating enable, and an Rx phase resync so the receiver can align its sampling to a start-bit edge without disturbing the Tx cadence.

## Interface
- CLK_HZ, 50000000, input clock frequency in Hz.
- BAUD, 115200, default baud rate.
- OVERSAMPLE, 16, Rx strobes per bit; must be ≥2.
- DIV_WIDTH, 16, width of the divisor register and prescalers.
- DEFAULT_DIV, CLK_HZ/(BAUD*OVERSAMPLE) (=27), reset divisor; elaboration error unless 2 ≤ DEFAULT_DIV < 2^DIV_WIDTH.
- clk_50m  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable; 0 freezes all counters.
- div_wr  input  1  one-cycle write strobe for div_in.
- div_in  input  DIV_WIDTH  new divisor (clock cycles per Rx strobe).
- rx_resync  input  1  restart Rx prescaler phase.
- rx_tick  output  1  registered one-cycle Rx oversample strobe.
- tx_tick  output  1  registered one-cycle Tx bit strobe.
- div_cur  output  DIV_WIDTH  current divisor register.
- div_err  output  1  registered one-cycle pulse: rejected divisor write.

## Operation
- State: div_reg (DIV_WIDTH), rx_pre (DIV_WIDTH), tx_pre (DIV_WIDTH), tx_os ($clog2(OVERSAMPLE)), plus registered rx_tick, tx_tick, div_err. div_cur = div_reg.
- Priority per edge: reset > accepted div_wr > rx_resync (Rx path only) > en counting.
- reset: div_reg←DEFAULT_DIV; rx_pre, tx_pre, tx_os←0; rx_tick, tx_tick, div_err←0.
- div_wr with div_in ≥ 2: div_reg←div_in; rx_pre, tx_pre, tx_os←0; both ticks←0; div_err←0. Accepted regardless of en.
- div_wr with div_in < 2 (0 or 1): div_reg unchanged, div_err←1 for one cycle; counting continues normally that edge.
- Rx path, en=1: if rx_pre == div_reg−1 then rx_pre←0, rx_tick←1; else rx_pre←rx_pre+1, rx_tick←0.
- rx_resync=1 (no accepted write): rx_pre←0, rx_tick←0, regardless of en; Tx path unaffected.
- Tx path, en=1: tx_pre wraps at div_reg−1 like rx_pre; on each wrap tx_os←tx_os+1 (wrap at OVERSAMPLE−1 to 0); tx_tick←1 only on the edge where tx_pre wraps and tx_os == OVERSAMPLE−1, else 0.
- en=0: all counters hold; rx_tick, tx_tick←0 next edge.
- All comparisons unsigned, DIV_WIDTH wide; counters never exceed div_reg−1.

## Timing
- Tick period: rx_tick every div_reg enabled cycles; tx_tick every div_reg×OVERSAMPLE enabled cycles (default 27 / 432 cycles, 115741 baud, +0.47 %).
- After reset deasserts with en=1, first rx_tick is high in the cycle after the 27th enabled edge; first tx_tick after the 432nd; both coincide then.
- Ticks are exactly one cycle wide for every div_reg ≥ 2; never back-to-back.
- Accepted div_wr at edge N: div_cur shows new value after N; next rx_tick high after edge N+div_in (if en held).
- rx_resync at edge N: next rx_tick high after edge N+div_reg; asserting rx_resync every cycle suppresses rx_tick entirely.
- div_err high exactly the cycle after the rejected write edge.
- Reset mid-count: outputs 0 after the reset edge, divisor restored to DEFAULT_DIV.

## Test plan
- Reset then en=1 for 1000 cycles -> rx_tick at cycles 27, 54, …; tx_tick at 432, 864; div_cur=27.
- div_wr, div_in=5 mid-count -> div_cur=5, rx_tick every 5 cycles, tx_tick every 80, first rx_tick 5 cycles after write.
- div_wr with div_in=0 and 1 -> div_err one-cycle pulse each, div_cur unchanged, tick cadence undisturbed.
- rx_resync at rx_pre=13 -> next rx_tick 27 cycles later; tx_tick timing unchanged (still multiple of 432 from reset).
- en low for 100 cycles at rx_pre=10 -> no ticks; after en high, rx_tick after 17 more cycles.
- reset asserted during tx_os=15 with div_reg=5 -> ticks 0, div_cur=27, cadence restarts from zero.
